// File: rtl/accelerator_dnc_pkg.sv
// Shared definitions for the DNC memory-path accelerators: FSM states,
// scalar constants and an address-width helper.
package accelerator_dnc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    W_LOAD   = 2'd1,
    L_STREAM = 2'd2,
    DONE     = 2'd3
  } dnc_state_e;

  localparam logic ZERO = 1'b0;
  localparam logic ONE  = 1'b1;

  // A depth of one still needs a one-bit address port.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/accelerator_backward_weighting_if.sv
// Handshake and data bus of the backward weighting engine; the master drives
// sizes, strobes and words, the slave answers with requests and results.
interface accelerator_backward_weighting_if #(
  parameter int DATA_SIZE = 64
);
  logic                 start;
  logic                 ready;
  logic                 w_in_enable;
  logic                 l_in_enable;
  logic                 w_i_enable;
  logic                 l_j_enable;
  logic                 b_out_enable;
  logic                 b_out_i_enable;
  logic                 b_out_j_enable;
  logic [DATA_SIZE-1:0] size_r_in;
  logic [DATA_SIZE-1:0] size_n_in;
  logic [DATA_SIZE-1:0] w_in;
  logic [DATA_SIZE-1:0] l_in;
  logic [DATA_SIZE-1:0] b_out;

  modport master (
    output start, w_in_enable, l_in_enable, size_r_in, size_n_in, w_in, l_in,
    input  ready, w_i_enable, l_j_enable, b_out_enable, b_out_i_enable,
           b_out_j_enable, b_out
  );

  modport slave (
    input  start, w_in_enable, l_in_enable, size_r_in, size_n_in, w_in, l_in,
    output ready, w_i_enable, l_j_enable, b_out_enable, b_out_i_enable,
           b_out_j_enable, b_out
  );
endinterface

// File: rtl/accelerator_vector_buffer.sv
// Row buffer: single write port, asynchronous read port. Contents survive
// reset on purpose so the block stays a plain register file.
module accelerator_vector_buffer
  import accelerator_dnc_pkg::*;
#(
  parameter int DATA_SIZE = 64,
  parameter int MAX_N     = 64,
  parameter int ADDR_W    = addr_width(MAX_N)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DATA_SIZE-1:0] rd_data
);

  logic [DATA_SIZE-1:0] mem_r [MAX_N];

  // Store one word per accepted write strobe.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/accelerator_backward_weighting.sv
// DNC backward weighting b(i) = L^T * w(i): buffers one w row, then runs one
// MAC over each column of L and emits one registered b word per column.
module accelerator_backward_weighting
  import accelerator_dnc_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int MAX_N        = 64
) (
  input logic                             clk,
  input logic                             rst,
  accelerator_backward_weighting_if.slave bus
);

  localparam int ADDR_W = addr_width(MAX_N);

  dnc_state_e              state_r, state_nxt_s;
  logic [CONTROL_SIZE-1:0] r_size_r, r_size_nxt_s, n_size_r, n_size_nxt_s;
  logic [CONTROL_SIZE-1:0] i_r, i_nxt_s, j_r, j_nxt_s, g_r, g_nxt_s;
  logic [CONTROL_SIZE-1:0] n_last_s, r_last_s;
  logic [DATA_SIZE-1:0]    acc_r, acc_nxt_s, b_out_r, b_out_nxt_s;
  logic [DATA_SIZE-1:0]    n_sat_s, rd_data_s, mac_s;
  logic                    ready_r, ready_nxt_s, w_i_enable_r, w_i_enable_nxt_s;
  logic                    l_j_enable_r, l_j_enable_nxt_s;
  logic                    b_out_enable_r, b_out_enable_nxt_s;
  logic                    b_out_i_enable_r, b_out_i_enable_nxt_s;
  logic                    wr_en_s;

  assign n_sat_s  = (bus.size_n_in > DATA_SIZE'(MAX_N)) ? DATA_SIZE'(MAX_N) : bus.size_n_in;
  assign n_last_s = n_size_r - CONTROL_SIZE'(1);
  assign r_last_s = r_size_r - CONTROL_SIZE'(1);
  assign mac_s    = acc_r + bus.l_in * rd_data_s;
  assign wr_en_s  = (state_r == W_LOAD) && bus.w_in_enable;

  accelerator_vector_buffer #(
    .DATA_SIZE (DATA_SIZE),
    .MAX_N     (MAX_N),
    .ADDR_W    (ADDR_W)
  ) u_w_buffer (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (g_r[ADDR_W-1:0]),
    .wr_data (bus.w_in),
    .rd_addr (g_r[ADDR_W-1:0]),
    .rd_data (rd_data_s)
  );

  // Next-state, counter, MAC and output decisions; unmatched strobes fall through unchanged.
  always_comb begin
    state_nxt_s          = state_r;
    r_size_nxt_s         = r_size_r;
    n_size_nxt_s         = n_size_r;
    i_nxt_s              = i_r;
    j_nxt_s              = j_r;
    g_nxt_s              = g_r;
    acc_nxt_s            = acc_r;
    b_out_nxt_s          = b_out_r;
    ready_nxt_s          = ZERO;
    w_i_enable_nxt_s     = ZERO;
    l_j_enable_nxt_s     = ZERO;
    b_out_enable_nxt_s   = ZERO;
    b_out_i_enable_nxt_s = ZERO;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          r_size_nxt_s = CONTROL_SIZE'(bus.size_r_in);
          n_size_nxt_s = CONTROL_SIZE'(n_sat_s);
          i_nxt_s      = '0;
          j_nxt_s      = '0;
          g_nxt_s      = '0;
          acc_nxt_s    = '0;
          if ((bus.size_r_in == '0) || (n_sat_s == '0)) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s      = W_LOAD;
            w_i_enable_nxt_s = ONE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      W_LOAD: begin
        if (bus.w_in_enable) begin
          if (g_r == n_last_s) begin
            state_nxt_s      = L_STREAM;
            g_nxt_s          = '0;
            j_nxt_s          = '0;
            acc_nxt_s        = '0;
            l_j_enable_nxt_s = ONE;
          end else begin
            g_nxt_s = g_r + CONTROL_SIZE'(1);
          end
        end else begin
          state_nxt_s = W_LOAD;
        end
      end
      L_STREAM: begin
        if (bus.l_in_enable) begin
          if (g_r == n_last_s) begin
            // Column complete: publish the sum and pick the next column, row or finish.
            b_out_nxt_s          = mac_s;
            b_out_enable_nxt_s   = ONE;
            b_out_i_enable_nxt_s = (j_r == '0) ? ONE : ZERO;
            acc_nxt_s            = '0;
            g_nxt_s              = '0;
            if (j_r != n_last_s) begin
              j_nxt_s          = j_r + CONTROL_SIZE'(1);
              l_j_enable_nxt_s = ONE;
            end else if (i_r != r_last_s) begin
              i_nxt_s          = i_r + CONTROL_SIZE'(1);
              j_nxt_s          = '0;
              state_nxt_s      = W_LOAD;
              w_i_enable_nxt_s = ONE;
            end else begin
              state_nxt_s = DONE;
            end
          end else begin
            acc_nxt_s = mac_s;
            g_nxt_s   = g_r + CONTROL_SIZE'(1);
          end
        end else begin
          state_nxt_s = L_STREAM;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
        ready_nxt_s = ONE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, counters, accumulator and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      r_size_r         <= '0;
      n_size_r         <= '0;
      i_r              <= '0;
      j_r              <= '0;
      g_r              <= '0;
      acc_r            <= '0;
      b_out_r          <= '0;
      ready_r          <= ZERO;
      w_i_enable_r     <= ZERO;
      l_j_enable_r     <= ZERO;
      b_out_enable_r   <= ZERO;
      b_out_i_enable_r <= ZERO;
    end else begin
      state_r          <= state_nxt_s;
      r_size_r         <= r_size_nxt_s;
      n_size_r         <= n_size_nxt_s;
      i_r              <= i_nxt_s;
      j_r              <= j_nxt_s;
      g_r              <= g_nxt_s;
      acc_r            <= acc_nxt_s;
      b_out_r          <= b_out_nxt_s;
      ready_r          <= ready_nxt_s;
      w_i_enable_r     <= w_i_enable_nxt_s;
      l_j_enable_r     <= l_j_enable_nxt_s;
      b_out_enable_r   <= b_out_enable_nxt_s;
      b_out_i_enable_r <= b_out_i_enable_nxt_s;
    end
  end

  assign bus.ready          = ready_r;
  assign bus.w_i_enable     = w_i_enable_r;
  assign bus.l_j_enable     = l_j_enable_r;
  assign bus.b_out_enable   = b_out_enable_r;
  assign bus.b_out_i_enable = b_out_i_enable_r;
  assign bus.b_out_j_enable = b_out_enable_r;
  assign bus.b_out          = b_out_r;

endmodule

// File: tb/tb_accelerator_backward_weighting.sv
// Randomised bench for accelerator_backward_weighting: a matrix-level model
// predicts every b word, a negedge monitor compares each output cycle.
module tb_accelerator_backward_weighting;

  localparam int DW   = 64;
  localparam int MAXN = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  accelerator_backward_weighting_if #(.DATA_SIZE(DW)) bus ();

  accelerator_backward_weighting #(
    .DATA_SIZE    (DW),
    .CONTROL_SIZE (64),
    .MAX_N        (MAXN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] val;
    bit          first;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  exp_t        exp_q[$];
  logic [63:0] w_m [0:3][0:MAXN-1];
  logic [63:0] l_m [0:MAXN-1][0:MAXN-1];
  int          ready_cnt = 0;
  int          wreq_cnt  = 0;
  int          lreq_cnt  = 0;
  logic [63:0] last_b    = 64'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: b(i;j) = sum over g of L(g;j)*w(i;g), modulo 2^64.
  function automatic logic [63:0] model_b(input int i, input int j, input int n);
    logic [63:0] acc;
    logic [63:0] prod;
    acc = 64'd0;
    for (int g = 0; g < n; g++) begin
      prod = l_m[g][j] * w_m[i][g];
      acc  = acc + prod;
    end
    return acc;
  endfunction

  function automatic bit sig(input int which);
    case (which)
      0:       return bus.w_i_enable;
      1:       return bus.l_j_enable;
      default: return bus.ready;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string name);
    int n;
    n = 0;
    while (!sig(which) && n < 64) begin
      tick();
      n++;
    end
    check(name, 64'(sig(which)), 64'd1);
  endtask

  // Output monitor: every non-reset cycle is either a predicted b word or a hold cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_b = 64'd0;
      end else begin
        if (bus.ready)      ready_cnt++;
        if (bus.w_i_enable) wreq_cnt++;
        if (bus.l_j_enable) lreq_cnt++;
        if (bus.b_out_enable) begin
          if (exp_q.size() == 0) begin
            check("unexpected_b_out_enable", 64'(bus.b_out_enable), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("b_out", bus.b_out, e.val);
            check("b_out_i_enable", 64'(bus.b_out_i_enable), 64'(e.first));
            check("b_out_j_enable", 64'(bus.b_out_j_enable), 64'd1);
          end
          last_b = bus.b_out;
        end else begin
          check("b_out_hold", bus.b_out, last_b);
          check("ij_enable_idle", 64'({bus.b_out_i_enable, bus.b_out_j_enable}), 64'd0);
        end
      end
    end
  end

  task automatic send_word(input bit is_w, input logic [63:0] d, input bit gaps);
    int k;
    if (gaps) begin
      k = $urandom_range(0, 3);
      repeat (k) begin
        if (is_w) begin
          bus.l_in_enable = 1'($urandom_range(0, 1));
          bus.l_in        = {$urandom, $urandom};
          bus.start       = 1'($urandom_range(0, 1));
        end else begin
          bus.w_in_enable = 1'($urandom_range(0, 1));
          bus.w_in        = {$urandom, $urandom};
        end
        tick();
        bus.l_in_enable = 1'b0;
        bus.w_in_enable = 1'b0;
        bus.start       = 1'b0;
      end
    end
    if (is_w) begin
      bus.w_in_enable = 1'b1;
      bus.w_in        = d;
    end else begin
      bus.l_in_enable = 1'b1;
      bus.l_in        = d;
    end
    tick();
    bus.w_in_enable = 1'b0;
    bus.l_in_enable = 1'b0;
  endtask

  task automatic run(input int r, input int n_in, input bit gaps, input bit abort);
    int n, r0, w0, l0;
    exp_t e;
    n  = (n_in > MAXN) ? MAXN : n_in;
    r0 = ready_cnt;
    w0 = wreq_cnt;
    l0 = lreq_cnt;
    if (!abort) begin
      for (int i = 0; i < r; i++) begin
        for (int j = 0; j < n; j++) begin
          e.val   = model_b(i, j, n);
          e.first = (j == 0);
          exp_q.push_back(e);
        end
      end
    end
    bus.size_r_in = 64'(r);
    bus.size_n_in = 64'(n_in);
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < r; i++) begin
      wait_sig(0, "w_i_enable_request");
      for (int g = 0; g < n; g++) send_word(1'b1, w_m[i][g], gaps);
      for (int j = 0; j < n; j++) begin
        wait_sig(1, "l_j_enable_request");
        for (int g = 0; g < n; g++) begin
          send_word(1'b0, l_m[g][j], gaps);
          if (abort) return;
        end
      end
    end
    wait_sig(2, "ready");
    repeat (4) tick();
    check("ready_pulses", 64'(ready_cnt - r0), 64'd1);
    check("results_drained", 64'(exp_q.size()), 64'd0);
    check("w_i_enable_pulses", 64'(wreq_cnt - w0), 64'(r));
    check("l_j_enable_pulses", 64'(lreq_cnt - l0), 64'(r * n));
  endtask

  task automatic load_test1();
    w_m[0][0] = 64'd5; w_m[0][1] = 64'd6;
    l_m[0][0] = 64'd1; l_m[1][0] = 64'd3;
    l_m[0][1] = 64'd2; l_m[1][1] = 64'd4;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_b_out"}, bus.b_out, 64'd0);
    check({name, "_flags"}, 64'({bus.ready, bus.w_i_enable, bus.l_j_enable,
                                 bus.b_out_enable, bus.b_out_i_enable, bus.b_out_j_enable}), 64'd0);
  endtask

  initial begin
    int r0, w0, l0, rr, nn;
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0, l0, rr, nn;
    rst = 1'b1;
    bus.start = 1'b0; bus.w_in_enable = 1'b0; bus.l_in_enable = 1'b0;
    bus.size_r_in = 64'd0; bus.size_n_in = 64'd0; bus.w_in = 64'd0; bus.l_in = 64'd0;
    repeat (3) tick();
    check_all_zero("reset_state");
    rst = 1'b0;
    tick();

    // Test 1 and its hand-computed pins.
    load_test1();
    check("model_pin_t1_j0", model_b(0, 0, 2), 64'd23);
    check("model_pin_t1_j1", model_b(0, 1, 2), 64'd34);
    run(1, 2, 1'b0, 1'b0);

    // Test 2: second row [1,0].
    w_m[1][0] = 64'd1; w_m[1][1] = 64'd0;
    check("model_pin_t2_j0", model_b(1, 0, 2), 64'd1);
    check("model_pin_t2_j1", model_b(1, 1, 2), 64'd2);
    run(2, 2, 1'b0, 1'b0);

    // Test 3: zero-size runs finish two clocks after START.
    for (int k = 0; k < 2; k++) begin
      r0 = ready_cnt; w0 = wreq_cnt; l0 = lreq_cnt;
      bus.size_r_in = (k == 0) ? 64'd1 : 64'd0;
      bus.size_n_in = (k == 0) ? 64'd0 : 64'd3;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("zero_ready_early", 64'(bus.ready), 64'd0);
      tick();
      check("zero_ready_at_2", 64'(bus.ready), 64'd1);
      tick();
      check("zero_ready_once", 64'(bus.ready), 64'd0);
      tick();
      check("zero_ready_count", 64'(ready_cnt - r0), 64'd1);
      check("zero_no_requests", 64'((wreq_cnt - w0) + (lreq_cnt - l0)), 64'd0);
    end

    // Test 4: wrap-around of product and sum.
    w_m[0][0] = 64'h1_0000_0000; l_m[0][0] = 64'h1_0000_0000;
    check("model_pin_wrap0", model_b(0, 0, 1), 64'd0);
    run(1, 1, 1'b0, 1'b0);
    w_m[0][0] = 64'hFFFF_FFFF_FFFF_FFFF; l_m[0][0] = 64'hFFFF_FFFF_FFFF_FFFF;
    check("model_pin_wrap1", model_b(0, 0, 1), 64'd1);
    run(1, 1, 1'b0, 1'b0);

    // Test 5: test 1 with gaps and stray strobes.
    load_test1();
    repeat (3) run(1, 2, 1'b1, 1'b0);

    // Test 6: reset after the first L word, then a clean rerun.
    r0 = ready_cnt;
    run(1, 2, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    check_all_zero("mid_reset");
    rst = 1'b0;
    repeat (6) tick();
    check("mid_reset_no_ready", 64'(ready_cnt - r0), 64'd0);
    run(1, 2, 1'b0, 1'b0);

    // Randomised sizes and data.
    for (int t = 0; t < 6; t++) begin
      rr = $urandom_range(1, 3);
      nn = $urandom_range(1, 6);
      for (int i = 0; i < rr; i++)
        for (int g = 0; g < nn; g++) w_m[i][g] = {$urandom, $urandom};
      for (int g = 0; g < nn; g++)
        for (int j = 0; j < nn; j++) l_m[g][j] = {$urandom, $urandom};
      run(rr, nn, 1'b1, 1'b0);
    end

    // N above the buffer depth saturates to MAXN.
    for (int g = 0; g < MAXN; g++) begin
      w_m[0][g] = 64'($urandom);
      for (int j = 0; j < MAXN; j++) l_m[g][j] = 64'($urandom_range(0, 1000));
    end
    run(1, MAXN + 6, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
